// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_arbiter
//  Description : Two-requester round-robin arbiter in front of a single-port
//                data memory with registered read data. One transaction in
//                flight at a time; out-of-range addresses are answered with
//                an error response and never reach the memory.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 1024
) (
   input  logic             clk,
   input  logic             reset,
   // requester 0
   input  logic             r0_req,
   input  logic             r0_we,
   input  logic [WIDTH-1:0] r0_addr,
   input  logic [WIDTH-1:0] r0_wdata,
   output logic             r0_ack,
   output logic [WIDTH-1:0] r0_rdata,
   output logic             r0_err,
   // requester 1
   input  logic             r1_req,
   input  logic             r1_we,
   input  logic [WIDTH-1:0] r1_addr,
   input  logic [WIDTH-1:0] r1_wdata,
   output logic             r1_ack,
   output logic [WIDTH-1:0] r1_rdata,
   output logic             r1_err,
   // memory side
   output logic             mem_read,
   output logic             mem_write,
   output logic [WIDTH-1:0] mem_address,
   output logic [WIDTH-1:0] mem_write_data,
   input  logic [WIDTH-1:0] mem_read_data,
   output logic             busy
);

   // One extra bit so a DEPTH equal to 2**WIDTH still compares correctly.
   localparam logic [WIDTH:0] c_depth = (WIDTH+1)'(DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ISSUE   = 2'd1,
      ST_CAPTURE = 2'd2,
      ST_RESP    = 2'd3
   } state_t;

   state_t           r_state;
   state_t           w_next_state;

   logic             r_owner;        // requester holding the current transaction
   logic             r_last;         // last granted requester (round-robin pointer)
   logic             r_we;
   logic             r_err;
   logic [WIDTH-1:0] r_mem_address;
   logic [WIDTH-1:0] r_mem_write_data;
   logic [WIDTH-1:0] r_rdata0;
   logic [WIDTH-1:0] r_rdata1;

   logic             w_any_req;
   logic             w_grant_id;
   logic             w_sel_we;
   logic [WIDTH-1:0] w_sel_addr;
   logic [WIDTH-1:0] w_sel_wdata;
   logic             w_in_range;
   logic             w_mem_read;
   logic             w_mem_write;
   logic             w_ack0;
   logic             w_ack1;

   // On a tie the requester that was not granted last wins.
   assign w_any_req   = r0_req | r1_req;
   assign w_grant_id  = (r0_req & r1_req) ? ~r_last : r1_req;
   assign w_sel_we    = w_grant_id ? r1_we    : r0_we;
   assign w_sel_addr  = w_grant_id ? r1_addr  : r0_addr;
   assign w_sel_wdata = w_grant_id ? r1_wdata : r0_wdata;
   assign w_in_range  = ({1'b0, w_sel_addr} < c_depth);

   // State register; reset abandons any transaction in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state logic plus the single-cycle memory strobes and acks.
   always_comb begin
      w_next_state = r_state;
      w_mem_read   = 1'b0;
      w_mem_write  = 1'b0;
      w_ack0       = 1'b0;
      w_ack1       = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_any_req) begin
               w_next_state = w_in_range ? ST_ISSUE : ST_RESP;
            end
         end
         ST_ISSUE: begin
            w_mem_read   = ~r_we;
            w_mem_write  = r_we;
            w_next_state = ST_CAPTURE;
         end
         ST_CAPTURE: begin
            w_next_state = ST_RESP;
         end
         ST_RESP: begin
            w_ack0       = ~r_owner;
            w_ack1       = r_owner;
            w_next_state = ST_IDLE;
         end
         default: begin
            w_next_state = ST_IDLE;
         end
      endcase
   end

   // Latch the granted request and capture read data into the owner's register.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_owner          <= 1'b0;
         r_last           <= 1'b1;
         r_we             <= 1'b0;
         r_err            <= 1'b0;
         r_mem_address    <= '0;
         r_mem_write_data <= '0;
         r_rdata0         <= '0;
         r_rdata1         <= '0;
      end else begin
         if ((r_state == ST_IDLE) && w_any_req) begin
            r_owner          <= w_grant_id;
            r_last           <= w_grant_id;
            r_we             <= w_sel_we;
            r_err            <= ~w_in_range;
            r_mem_address    <= w_sel_addr;
            r_mem_write_data <= w_sel_wdata;
            // An error response returns zero data to the requester.
            if (!w_in_range) begin
               if (w_grant_id) begin
                  r_rdata1 <= '0;
               end else begin
                  r_rdata0 <= '0;
               end
            end
         end
         if ((r_state == ST_CAPTURE) && !r_we) begin
            if (r_owner) begin
               r_rdata1 <= mem_read_data;
            end else begin
               r_rdata0 <= mem_read_data;
            end
         end
      end
   end

   assign mem_read       = w_mem_read;
   assign mem_write      = w_mem_write;
   assign mem_address    = r_mem_address;
   assign mem_write_data = r_mem_write_data;
   assign r0_ack         = w_ack0;
   assign r1_ack         = w_ack1;
   assign r0_err         = w_ack0 & r_err;
   assign r1_err         = w_ack1 & r_err;
   assign r0_rdata       = r_rdata0;
   assign r1_rdata       = r_rdata1;
   assign busy           = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_arbiter
//  Description : Self-checking bench for dmem_arbiter with a registered-read
//                memory model and a queue of expected responses.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;
   localparam int WIDTH = 32;
   localparam int DEPTH = 1024;

   logic             clk = 1'b0;
   logic             reset;
   logic             r0_req, r0_we, r1_req, r1_we;
   logic [WIDTH-1:0] r0_addr, r0_wdata, r1_addr, r1_wdata;
   logic             r0_ack, r0_err, r1_ack, r1_err;
   logic [WIDTH-1:0] r0_rdata, r1_rdata;
   logic             mem_read, mem_write, busy;
   logic [WIDTH-1:0] mem_address, mem_write_data;
   logic [WIDTH-1:0] mem_read_data = '0;

   always #5 clk = ~clk;

   dmem_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset),
      .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
      .r0_ack(r0_ack), .r0_rdata(r0_rdata), .r0_err(r0_err),
      .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
      .r1_ack(r1_ack), .r1_rdata(r1_rdata), .r1_err(r1_err),
      .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
      .mem_write_data(mem_write_data), .mem_read_data(mem_read_data), .busy(busy)
   );

   // memory model with registered read data
   logic [WIDTH-1:0] mem     [0:DEPTH-1];
   logic [WIDTH-1:0] exp_mem [0:DEPTH-1];
   always @(posedge clk) begin
      if (mem_write) mem[mem_address[9:0]] <= mem_write_data;
      if (mem_read)  mem_read_data <= mem[mem_address[9:0]];
   end

   // protocol counters sampled away from the active edge
   int n_rd = 0, n_wr = 0, n_both = 0, n_outside = 0, n_overlap = 0;
   always @(negedge clk) begin
      if (mem_read)  n_rd++;
      if (mem_write) n_wr++;
      if (mem_read && mem_write) n_both++;
      if ((mem_read || mem_write) && !busy) n_outside++;
      if (r0_ack && r1_ack) n_overlap++;
   end

   typedef struct {
      logic             id;
      logic [WIDTH-1:0] data;
      logic             err;
      int               lat;
   } exp_t;
   exp_t sb[$];

   int n_pass  = 0;
   int n_total = 0;
   logic [WIDTH-1:0] last_r0 = '0, last_r1 = '0;

   // Drives one request from IDLE, waits (bounded) for its ack, drops req on the
   // ack cycle and returns in the following IDLE cycle. lat = -1 on timeout.
   task automatic do_access(input logic id, input logic we, input logic [WIDTH-1:0] addr,
                            input logic [WIDTH-1:0] wdata, output int lat,
                            output logic [WIDTH-1:0] rdata, output logic err);
      bit done = 0;
      lat = 0;
      if (id) begin r1_we = we; r1_addr = addr; r1_wdata = wdata; r1_req = 1'b1; end
      else    begin r0_we = we; r0_addr = addr; r0_wdata = wdata; r0_req = 1'b1; end
      while (!done && lat < 20) begin
         @(negedge clk);
         lat++;
         if (id ? r1_ack : r0_ack) done = 1;
      end
      rdata = id ? r1_rdata : r0_rdata;
      err   = id ? r1_err   : r0_err;
      if (!done) lat = -1;
      r0_req = 1'b0;
      r1_req = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      reset = 1'b1; r0_req = 1'b1; r0_we = 1'b0; r0_addr = 5;
      repeat (2) @(negedge clk);
      n_total++;
      if ({r0_ack, r1_ack, r0_err, r1_err, mem_read, mem_write, busy} !== 7'b0)
         $display("FAIL reset_ctrl: got %b expected 0000000",
                  {r0_ack, r1_ack, r0_err, r1_err, mem_read, mem_write, busy});
      else n_pass++;
      n_total++;
      if ({r0_rdata, r1_rdata} !== '0)
         $display("FAIL reset_rdata: got %h %h expected 0 0", r0_rdata, r1_rdata);
      else n_pass++;
      n_total++;
      if ({mem_address, mem_write_data} !== '0)
         $display("FAIL reset_mem: got %h %h expected 0 0", mem_address, mem_write_data);
      else n_pass++;
      r0_req = 1'b0;
      reset  = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_read();
      int lat; logic [WIDTH-1:0] d; logic e; exp_t x; int rd0, wr0;
      rd0 = n_rd; wr0 = n_wr;
      sb.push_back('{id: 1'b0, data: exp_mem[5], err: 1'b0, lat: 3});
      do_access(1'b0, 1'b0, 5, '0, lat, d, e);
      x = sb.pop_front();
      last_r0 = x.data;
      n_total++;
      if (lat !== x.lat) $display("FAIL read_latency: got %0d expected %0d", lat, x.lat); else n_pass++;
      n_total++;
      if (d !== x.data) $display("FAIL read_data: got %h expected %h", d, x.data); else n_pass++;
      n_total++;
      if (e !== x.err) $display("FAIL read_err: got %b expected %b", e, x.err); else n_pass++;
      n_total++;
      if ((n_rd - rd0) != 1 || (n_wr - wr0) != 0)
         $display("FAIL read_strobes: got rd=%0d wr=%0d expected rd=1 wr=0", n_rd - rd0, n_wr - wr0);
      else n_pass++;
   endtask

   task automatic test_write_then_read();
      int lat; logic [WIDTH-1:0] d; logic e; exp_t x; int rd0, wr0;
      rd0 = n_rd; wr0 = n_wr;
      // a write leaves the requester's rdata unchanged
      sb.push_back('{id: 1'b1, data: last_r1, err: 1'b0, lat: 3});
      exp_mem[10] = 32'h12345678;
      do_access(1'b1, 1'b1, 10, 32'h12345678, lat, d, e);
      x = sb.pop_front();
      n_total++;
      if (lat !== x.lat || e !== x.err)
         $display("FAIL write_ack: got lat=%0d err=%b expected lat=%0d err=%b", lat, e, x.lat, x.err);
      else n_pass++;
      n_total++;
      if (d !== x.data) $display("FAIL write_rdata_hold: got %h expected %h", d, x.data); else n_pass++;
      n_total++;
      if ((n_wr - wr0) != 1 || (n_rd - rd0) != 0)
         $display("FAIL write_strobes: got wr=%0d rd=%0d expected wr=1 rd=0", n_wr - wr0, n_rd - rd0);
      else n_pass++;
      sb.push_back('{id: 1'b0, data: exp_mem[10], err: 1'b0, lat: 3});
      do_access(1'b0, 1'b0, 10, '0, lat, d, e);
      x = sb.pop_front();
      last_r0 = x.data;
      n_total++;
      if (lat !== x.lat || d !== x.data || e !== x.err)
         $display("FAIL readback: got lat=%0d data=%h err=%b expected lat=%0d data=%h err=%b",
                  lat, d, e, x.lat, x.data, x.err);
      else n_pass++;
   endtask

   task automatic test_out_of_range();
      int lat; logic [WIDTH-1:0] d; logic e; exp_t x; int rd0, wr0;
      rd0 = n_rd; wr0 = n_wr;
      sb.push_back('{id: 1'b0, data: '0, err: 1'b1, lat: 1});
      do_access(1'b0, 1'b0, DEPTH, '0, lat, d, e);
      x = sb.pop_front();
      last_r0 = x.data;
      n_total++;
      if (lat !== x.lat) $display("FAIL oor_latency: got %0d expected %0d", lat, x.lat); else n_pass++;
      n_total++;
      if (d !== x.data || e !== x.err)
         $display("FAIL oor_resp: got data=%h err=%b expected data=%h err=%b", d, e, x.data, x.err);
      else n_pass++;
      n_total++;
      if ((n_rd - rd0) != 0 || (n_wr - wr0) != 0)
         $display("FAIL oor_strobes: got rd=%0d wr=%0d expected 0 0", n_rd - rd0, n_wr - wr0);
      else n_pass++;
      rd0 = n_rd;
      sb.push_back('{id: 1'b0, data: exp_mem[DEPTH-1], err: 1'b0, lat: 3});
      do_access(1'b0, 1'b0, DEPTH-1, '0, lat, d, e);
      x = sb.pop_front();
      last_r0 = x.data;
      n_total++;
      if (lat !== x.lat || d !== x.data || e !== x.err || (n_rd - rd0) != 1)
         $display("FAIL boundary_addr: got lat=%0d data=%h err=%b rd=%0d expected lat=%0d data=%h err=%b rd=1",
                  lat, d, e, n_rd - rd0, x.lat, x.data, x.err);
      else n_pass++;
   endtask

   task automatic test_round_robin();
      int acks = 0, idle = 0, waited = 0, ov0;
      exp_t x;
      ov0 = n_overlap;
      reset = 1'b1;
      r0_we = 1'b0; r0_addr = 2; r0_req = 1'b1;
      r1_we = 1'b0; r1_addr = 3; r1_req = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 4; i++)
         sb.push_back('{id: i[0], data: exp_mem[i[0] ? 3 : 2], err: 1'b0, lat: 0});
      while (acks < 4 && waited < 40) begin
         @(negedge clk);
         waited++;
         if (r0_ack || r1_ack) begin
            x = sb.pop_front();
            n_total++;
            if (r1_ack !== x.id) $display("FAIL rr_order%0d: got r%0d expected r%0d", acks, r1_ack, x.id);
            else n_pass++;
            n_total++;
            if ((r1_ack ? r1_rdata : r0_rdata) !== x.data)
               $display("FAIL rr_data%0d: got %h expected %h", acks, r1_ack ? r1_rdata : r0_rdata, x.data);
            else n_pass++;
            if (acks > 0) begin
               n_total++;
               if (idle != 1) $display("FAIL rr_idle_gap%0d: got %0d expected 1", acks, idle); else n_pass++;
            end
            idle = 0;
            acks++;
         end else if (!busy) begin
            idle++;
         end
      end
      r0_req = 1'b0; r1_req = 1'b0;
      @(negedge clk);
      last_r0 = exp_mem[2]; last_r1 = exp_mem[3];
      n_total++;
      if (acks != 4) $display("FAIL rr_timeout: got %0d acks expected 4", acks); else n_pass++;
      n_total++;
      if (n_overlap != ov0) $display("FAIL rr_overlap: got %0d expected 0", n_overlap - ov0); else n_pass++;
      sb.delete();
   endtask

   task automatic test_reset_mid();
      int stray = 0, waited = 0;
      bit got = 0, got_id = 0;
      r1_we = 1'b0; r1_addr = 7; r1_wdata = 32'hCAFE0001; r1_req = 1'b1;
      repeat (2) @(negedge clk);            // ISSUE, then CAPTURE
      n_total++;
      if (busy !== 1'b1) $display("FAIL mid_busy: got %b expected 1", busy); else n_pass++;
      reset = 1'b1; r1_req = 1'b0;
      @(negedge clk);
      n_total++;
      if ({r0_ack, r1_ack, r0_err, r1_err, mem_read, mem_write, busy} !== 7'b0)
         $display("FAIL mid_reset_ctrl: got %b expected 0000000",
                  {r0_ack, r1_ack, r0_err, r1_err, mem_read, mem_write, busy});
      else n_pass++;
      n_total++;
      if ({r0_rdata, r1_rdata, mem_address, mem_write_data} !== '0)
         $display("FAIL mid_reset_data: got %h %h %h %h expected 0 0 0 0",
                  r0_rdata, r1_rdata, mem_address, mem_write_data);
      else n_pass++;
      reset = 1'b0;
      repeat (4) begin
         @(negedge clk);
         if (r0_ack || r1_ack) stray++;
      end
      n_total++;
      if (stray != 0) $display("FAIL mid_no_ack: got %0d acks expected 0", stray); else n_pass++;
      r0_we = 1'b0; r0_addr = 4; r0_req = 1'b1;
      r1_we = 1'b0; r1_addr = 6; r1_req = 1'b1;
      while (!got && waited < 20) begin
         @(negedge clk);
         waited++;
         if (r0_ack || r1_ack) begin got = 1; got_id = r1_ack; end
      end
      r0_req = 1'b0; r1_req = 1'b0;
      @(negedge clk);
      n_total++;
      if (!got || got_id !== 1'b0)
         $display("FAIL mid_tie_grant: got ack=%b id=%0d expected ack=1 id=0", got, got_id);
      else n_pass++;
   endtask

   task automatic test_protocol();
      n_total++;
      if (n_both != 0) $display("FAIL strobe_exclusive: got %0d expected 0", n_both); else n_pass++;
      n_total++;
      if (n_outside != 0) $display("FAIL strobe_outside_busy: got %0d expected 0", n_outside); else n_pass++;
      n_total++;
      if (n_overlap != 0) $display("FAIL ack_overlap: got %0d expected 0", n_overlap); else n_pass++;
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) begin
         mem[i]     = 32'hA5A50000 ^ WIDTH'(i);
         exp_mem[i] = 32'hA5A50000 ^ WIDTH'(i);
      end
      mem[5]     = 32'hDEADBEEF;
      exp_mem[5] = 32'hDEADBEEF;
      reset = 1'b1;
      r0_req = 1'b0; r0_we = 1'b0; r0_addr = '0; r0_wdata = '0;
      r1_req = 1'b0; r1_we = 1'b0; r1_addr = '0; r1_wdata = '0;
      @(negedge clk);
      test_reset();
      test_read();
      test_write_then_read();
      test_out_of_range();
      test_round_robin();
      test_reset_mid();
      test_protocol();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 32: data and address width in bits.
REQ-002 SHALL have parameter DEPTH, default 1024: number of words in the attached data memory.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 rN_req  input  1  (N=0,1) requester N access request, held high until rN_ack.
REQ-006 rN_we  input  1  1=write, 0=read; stable while rN_req high.
REQ-007 rN_addr  input  WIDTH  word address; stable while rN_req high.
REQ-008 rN_wdata  input  WIDTH  write data; stable while rN_req high.
REQ-009 rN_ack  output  1  one-cycle completion pulse to requester N.
REQ-010 rN_rdata  output  WIDTH  read data, valid while rN_ack high.
REQ-011 rN_err  output  1  address-out-of-range flag, valid while rN_ack high.
REQ-012 mem_read  output  1  memory read strobe.
REQ-013 mem_write  output  1  memory write strobe.
REQ-014 mem_address  output  WIDTH  memory word address.
REQ-015 mem_write_data  output  WIDTH  memory write data.
REQ-016 mem_read_data  input  WIDTH  memory registered read data; valid the cycle after the mem_read edge.
REQ-017 busy  output  1  high in any state other than IDLE.

Function
REQ-018 SHALL implement FSM states IDLE, ISSUE, CAPTURE, RESP; exactly one transaction in flight.
REQ-019 IDLE: no req -> stay; any req -> select owner (REQ-024), latch owner's we/addr/wdata; addr < DEPTH -> ISSUE; addr >= DEPTH -> RESP with err set.
REQ-020 ISSUE: assert mem_read (we=0) or mem_write (we=1) for exactly one cycle with latched address/data -> CAPTURE.
REQ-021 CAPTURE: strobes low; at edge, owner rdata register <= mem_read_data for reads (unchanged for writes) -> RESP.
REQ-022 RESP: owner's rN_ack=1 for exactly one cycle, other ack 0 -> IDLE unconditionally.
REQ-023 Latency: req sampled at IDLE edge k -> ack high during cycle after edge k+2 (in range) or after edge k (out of range); max throughput one access per 4 cycles.
REQ-024 Arbitration: round-robin via 1-bit last-grant pointer; one req -> grant it; both -> grant the requester not last granted; pointer updates on every grant, including error responses.
REQ-025 Out-of-range (addr >= DEPTH, boundary DEPTH-1 is legal): no memory strobe, rdata driven 0, err=1 at ack.
REQ-026 rN_err SHALL be 0 on every in-range ack; rN_rdata SHALL hold last value between acks.
REQ-027 mem_read and mem_write SHALL never be high together and SHALL be low outside ISSUE.
REQ-028 Req dropped by requester before ack: undefined for requester; arbiter still completes latched transaction and pulses ack.
REQ-029 Requester must drop req on the edge ending its ack; the IDLE cycle after RESP samples fresh req values.

Reset
REQ-030 On reset high at clk edge: state IDLE, rN_ack=0, rN_err=0, rN_rdata=0, mem_read=0, mem_write=0, mem_address=0, mem_write_data=0, busy=0, last-grant pointer=1 (r0 wins first tie).
REQ-031 Reset during ISSUE/CAPTURE/RESP SHALL abandon the transaction with no ack; a write strobe already sampled by memory is not undone.
REQ-032 Reset SHALL take priority over all FSM transitions in the same cycle.

Verification
REQ-033 r0 read addr 5 (mem[5]=0xDEADBEEF) -> mem_read one cycle, r0_ack 3 cycles after grant, r0_rdata=0xDEADBEEF, r0_err=0.
REQ-034 r1 write addr 10 data 0x12345678, then r0 read addr 10 -> exactly one mem_write cycle, r0_rdata=0x12345678.
REQ-035 r0 and r1 both req continuously from reset, reads -> grant order r0,r1,r0,r1; no ack overlap; busy low one cycle between transactions.
REQ-036 r0 read addr 1024 (DEPTH=1024) -> no strobes, r0_ack next cycle with r0_err=1, r0_rdata=0; addr 1023 -> normal access, err=0.
REQ-037 Reset asserted during CAPTURE of r1 read -> no r1_ack, all outputs at reset values next cycle, next tie granted to r0.
